// File: rtl/dmem_ctrl.sv
// Data-memory controller: bridges CPU byte-addressed loads/stores onto a
// single-port 32-bit synchronous SRAM, with read-modify-write for sub-word stores.
module dmem_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_ena,
  input  logic              dmem_wena,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_in,
  input  logic [1:0]        d_ram_instr,
  output logic [31:0]       dmem_out,
  output logic              dmem_busy,
  output logic              dmem_adel,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR       = 3'd1;
  localparam logic [2:0] RD       = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RMW_RD   = 3'd4;
  localparam logic [2:0] RMW_WAIT = 3'd5;
  localparam logic [2:0] RMW_WR   = 3'd6;
  localparam logic [2:0] ERR      = 3'd7;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [2:0]        state;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic              wena_q;
  logic [31:0]       merge_q;
  logic [31:0]       merged;
  logic [31:0]       byte_shift;
  logic [31:0]       half_shift;
  logic              misaligned;
  logic              addr_hi_unused;

  // Addresses wrap: bits above the SRAM word range are deliberately dropped.
  assign addr_hi_unused = ^dmem_addr[31:ADDR_W+2];

  assign misaligned = (d_ram_instr == SZ_HALF) ? dmem_addr[0] :
                      (d_ram_instr == SZ_BYTE) ? 1'b0 :
                      (dmem_addr[1:0] != 2'b00);

  assign byte_shift = sram_rdata >> {addr_q[1:0], 3'b000};
  assign half_shift = sram_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    merged = merge_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = data_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      default: ;
    endcase
  end

  assign dmem_busy  = (state != IDLE);
  assign dmem_adel  = (state == ERR);
  assign sram_ce    = (state == WR) || (state == RD) || (state == RMW_RD) || (state == RMW_WR);
  assign sram_we    = wena_q && ((state == WR) || (state == RMW_WR));
  assign sram_addr  = addr_q[ADDR_W+1:2];
  assign sram_wdata = (state == RMW_WR) ? merged : data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      wena_q   <= 1'b0;
      merge_q  <= '0;
      dmem_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_ena) begin
            addr_q <= dmem_addr[ADDR_W+1:0];
            data_q <= dmem_in;
            size_q <= d_ram_instr;
            wena_q <= dmem_wena;
            if (misaligned)
              state <= ERR;
            else if (!dmem_wena)
              state <= RD;
            else if ((d_ram_instr == SZ_HALF) || (d_ram_instr == SZ_BYTE))
              state <= RMW_RD;
            else
              state <= WR;
          end
        end
        RD:       state <= RD_WAIT;
        RD_WAIT: begin
          case (size_q)
            SZ_BYTE: dmem_out <= {24'h0, byte_shift[7:0]};
            SZ_HALF: dmem_out <= {16'h0, half_shift[15:0]};
            default: dmem_out <= sram_rdata;
          endcase
          state <= IDLE;
        end
        RMW_RD:   state <= RMW_WAIT;
        RMW_WAIT: begin
          merge_q <= sram_rdata;
          state   <= RMW_WR;
        end
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural synchronous SRAM.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_ena = 1'b0;
  logic        dmem_wena = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_in = '0;
  logic [1:0]  d_ram_instr = '0;
  logic [31:0] dmem_out;
  logic        dmem_busy;
  logic        dmem_adel;
  logic        sram_ce;
  logic        sram_we;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:2047];
  int unsigned we_total = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned n_busy, n_we, n_ce, n_adel;
  logic [31:0] we_data;
  logic [31:0] we_addr;
  int unsigned we_snap;
  logic [31:0] out_snap;

  dmem_ctrl #(.ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .dmem_ena(dmem_ena), .dmem_wena(dmem_wena),
    .dmem_addr(dmem_addr), .dmem_in(dmem_in), .d_ram_instr(d_ram_instr),
    .dmem_out(dmem_out), .dmem_busy(dmem_busy), .dmem_adel(dmem_adel),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        we_total = we_total + 1;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and record what the controller does until idle again.
  task automatic req(input logic wena, input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] size);
    dmem_ena = 1'b1; dmem_wena = wena; dmem_addr = addr; dmem_in = data; d_ram_instr = size;
    n_busy = 0; n_we = 0; n_ce = 0; n_adel = 0; we_data = '0; we_addr = '0;
    @(posedge clk); #1;
    dmem_ena = 1'b0;
    while (dmem_busy && n_busy < 10) begin
      if (sram_ce) n_ce++;
      if (sram_we) begin
        n_we++; we_data = sram_wdata; we_addr = {21'h0, sram_addr};
      end
      if (dmem_adel) n_adel++;
      @(posedge clk); #1;
      n_busy++;
    end
  endtask

  initial begin
    #1;
    check("rst_busy", {31'h0, dmem_busy}, 32'd0);
    check("rst_ce_we_adel", {29'h0, sram_ce, sram_we, dmem_adel}, 32'd0);
    check("rst_out", dmem_out, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    req(1'b1, 32'h10, 32'hDEADBEEF, 2'b00);
    check("wstore_busy", n_busy, 32'd1);
    check("wstore_addr", we_addr, 32'd4);
    check("wstore_data", we_data, 32'hDEADBEEF);
    req(1'b0, 32'h10, 32'h0, 2'b00);
    check("wload_busy", n_busy, 32'd2);
    check("wload_nowe", n_we, 32'd0);
    check("wload_out", dmem_out, 32'hDEADBEEF);

    req(1'b1, 32'h10, 32'h11223344, 2'b00);
    req(1'b1, 32'h12, 32'hFFFFFFAA, 2'b10);
    check("bstore_busy", n_busy, 32'd3);
    check("bstore_ce", n_ce, 32'd2);
    check("bstore_wdata", we_data, 32'h11AA3344);
    check("bstore_mem", mem[4], 32'h11AA3344);

    req(1'b0, 32'h12, 32'h0, 2'b01);
    check("hload_hi", dmem_out, 32'h000011AA);
    req(1'b0, 32'h13, 32'h0, 2'b10);
    check("bload_3", dmem_out, 32'h00000011);
    req(1'b0, 32'h10, 32'h0, 2'b10);
    check("bload_0", dmem_out, 32'h00000044);
    req(1'b1, 32'h10, 32'hABCD5566, 2'b01);
    check("hstore_wdata", we_data, 32'h11AA5566);
    req(1'b0, 32'h10, 32'h0, 2'b01);
    check("hload_lo", dmem_out, 32'h00005566);

    req(1'b0, 32'h11, 32'h0, 2'b00);
    check("mis_ld_busy", n_busy, 32'd1);
    check("mis_ld_adel", n_adel, 32'd1);
    check("mis_ld_ce", n_ce, 32'd0);
    check("mis_ld_out", dmem_out, 32'h00005566);
    req(1'b1, 32'h13, 32'h12345678, 2'b01);
    check("mis_st_adel", n_adel, 32'd1);
    check("mis_st_ce", n_ce, 32'd0);
    check("mis_st_mem", mem[4], 32'h11AA5566);
    check("mis_adel_clr", {31'h0, dmem_adel}, 32'd0);

    req(1'b1, 32'h13, 32'h00000077, 2'b10);
    check("bstore_odd", mem[4], 32'h77AA5566);
    req(1'b0, 32'h10, 32'h0, 2'b11);
    check("size11_load", dmem_out, 32'h77AA5566);

    req(1'b1, 32'h2010, 32'hCAFEF00D, 2'b00);
    check("wrap_addr", we_addr, 32'd4);
    check("wrap_mem", mem[4], 32'hCAFEF00D);

    req(1'b1, 32'h20, 32'h01020304, 2'b00);
    dmem_ena = 1'b1; dmem_wena = 1'b1; dmem_addr = 32'h21; dmem_in = 32'hEE; d_ram_instr = 2'b10;
    @(posedge clk); #1;
    dmem_ena = 1'b0;
    @(posedge clk); #1;
    check("rmw_wait_busy", {31'h0, dmem_busy}, 32'd1);
    we_snap = we_total;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'h0, dmem_busy}, 32'd0);
    check("abort_ce_we", {30'h0, sram_ce, sram_we}, 32'd0);
    check("abort_out", dmem_out, 32'h0);
    dmem_ena = 1'b1; dmem_wena = 1'b0; dmem_addr = 32'h20; d_ram_instr = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    check("abort_no_we", we_total - we_snap, 32'd0);
    check("abort_mem", mem[8], 32'h01020304);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_accept", {31'h0, dmem_busy}, 32'd1);
    dmem_ena = 1'b0;
    out_snap = 32'h0;
    for (int i = 0; i < 10 && dmem_busy; i++) begin
      @(posedge clk); #1;
    end
    check("post_rst_idle", {31'h0, dmem_busy}, 32'd0);
    check("post_rst_load", dmem_out, 32'h01020304);
    check("post_rst_we", we_total - we_snap, out_snap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the SRAM word-address width (2^ADDR_W words of 32 bits).
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dmem_ena  in  1  CPU data-memory request.
- dmem_wena  in  1  1 = store, 0 = load.
- dmem_addr  in  32  CPU byte address.
- dmem_in  in  32  store data, right-aligned.
- d_ram_instr  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- dmem_out  out  32  registered load result.
- dmem_busy  out  1  request in progress; the CPU holds its PC while this is high.
- dmem_adel  out  1  one-cycle misaligned-access pulse.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid one cycle after a read-enable edge.

Function
REQ-003 The FSM SHALL use states IDLE, WR, RD, RD_WAIT, RMW_RD, RMW_WAIT, RMW_WR and ERR.
REQ-004 dmem_busy SHALL equal (state != IDLE), decoded combinationally from the state register.
REQ-005 In IDLE with dmem_ena=1 at a rising edge, the block SHALL latch addr, data, size and wena, then move to:
- ERR if misaligned;
- WR for a word store;
- RMW_RD for a half or byte store;
- RD for a load.
REQ-006 dmem_ena SHALL be ignored in every state other than IDLE.
REQ-007 An access SHALL be misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]!=00. Byte accesses SHALL never be misaligned.
REQ-008 ERR SHALL last one cycle with dmem_adel=1 and sram_ce=0, leave dmem_out unchanged, and then return to IDLE.
REQ-009 sram_addr SHALL equal latched addr[ADDR_W+1:2]. Upper address bits SHALL be ignored, so addresses wrap modulo 2^(ADDR_W+2).
REQ-010 WR SHALL drive sram_ce=1, sram_we=1 and sram_wdata=latched data, then return to IDLE. Word-store busy time is 1 cycle.
REQ-011 RD SHALL drive sram_ce=1, sram_we=0, then go to RD_WAIT.
REQ-012 RD_WAIT SHALL drive sram_ce=0, capture the aligned sram_rdata into dmem_out at its closing edge, and return to IDLE. Load busy time is 2 cycles; dmem_out is valid in the first IDLE cycle.
REQ-013 Load alignment SHALL work as follows, with upper bits zero-filled (sign extension is done downstream):
- byte: dmem_out = rdata >> (8*addr[1:0]) masked to 8 bits;
- half: dmem_out = rdata >> (16*addr[1]) masked to 16 bits;
- word: dmem_out = rdata unchanged.
REQ-014 RMW_RD SHALL issue an SRAM read, then go to RMW_WAIT.
REQ-015 RMW_WAIT SHALL capture sram_rdata into an internal merge register, then go to RMW_WR.
REQ-016 RMW_WR SHALL write the merge result with sram_ce=1 and sram_we=1, then return to IDLE. Sub-word store busy time is 3 cycles.
REQ-017 The merge SHALL be little-endian:
- byte store: lane addr[1:0], bits [8k+7:8k], is replaced by data[7:0];
- half store: lane addr[1], bits [16h+15:16h], is replaced by data[15:0];
- all other bits are kept.
REQ-018 sram_we SHALL be high only in WR and RMW_WR.
REQ-019 sram_ce SHALL be high only in WR, RD, RMW_RD and RMW_WR.
REQ-020 Back-to-back requests SHALL be accepted on the first IDLE edge after the previous request completes, with no idle gap cycle required.

Reset
REQ-021 While reset=0, asynchronously:
- state SHALL be IDLE;
- dmem_out, the merge register and all latched request registers SHALL be 0;
- dmem_busy, dmem_adel, sram_ce and sram_we SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL abort the access, and no sram_we pulse SHALL follow the reset assertion.
REQ-023 After reset deasserts, the first rising edge SHALL accept a pending request.

Verification
REQ-024 Word store then load:
- stimulus: store 0xDEADBEEF to 0x10, then load word from 0x10;
- response: sram_addr=4, busy 1 then 2 cycles, dmem_out=0xDEADBEEF.
REQ-025 Byte store merge:
- preload word 4 = 0x11223344;
- stimulus: store byte 0xAA to 0x12;
- response: RMW write data 0x11AA3344, busy high for 3 cycles.
REQ-026 Half load:
- word 4 = 0x11AA3344;
- stimulus: load half from 0x12;
- response: dmem_out=0x000011AA.
REQ-027 Misaligned accesses:
- stimulus: load word from 0x11, then store half to 0x13;
- response: dmem_adel pulses one cycle each, sram_ce stays 0, dmem_out and memory are unchanged.
REQ-028 Reset mid-RMW:
- stimulus: assert reset during RMW_WAIT of a byte store;
- response: outputs go to 0 immediately, no sram_we occurs, and the target word keeps its old value.
REQ-029 Address wrap:
- stimulus: with ADDR_W=11, store a word to 0x2010;
- response: sram_addr=4.
